// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line plus valid/ready frame handoff with per-frame flags
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
  logic                 serial;
  logic [DATA_BITS-1:0] trans;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  modport master(input serial, ready, output trans, valid, parity_err, frame_err, overrun, busy);
  modport slave(output serial, ready, input trans, valid, parity_err, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with parity/stop options and a valid/ready frame output
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic             clk,
  input logic             rst_n,
  uart_rx_frame_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic                 r_prev;
  logic [CW-1:0]        r_clk;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift, r_trans;
  logic                 r_par, r_perr, r_ferr;
  logic                 r_valid, r_perr_o, r_ferr_o, r_ovr;
  logic                 w_rx, w_tick, w_last, w_load;
  assign w_rx = r_sync[1];
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_tick = r_clk == (r_state == START ? HALF : FULL);
    w_last = r_bit == (r_state == DATA ? LAST_D : LAST_S);
    w_load = 1'b0;
    case (r_state)
      IDLE:    if (r_prev && !w_rx) w_next = START;
      START:   if (w_tick) w_next = w_rx ? IDLE : DATA;
      DATA:    if (w_tick && w_last) w_next = PARITY_EN != 0 ? PARITY : STOP;
      PARITY:  if (w_tick) w_next = STOP;
      STOP:    if (w_tick && w_last) begin
        w_next = IDLE;
        w_load = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  // counters restart on every state entry; candidates clear while idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_prev   <= 1'b1;
      r_clk    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_trans  <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], bus.serial};
      r_prev <= w_rx;
      r_clk  <= (r_state == IDLE || w_tick || r_state != w_next) ? '0 : r_clk + CW'(1);
      r_bit  <= r_state != w_next ? '0 : (w_tick ? r_bit + BW'(1) : r_bit);
      if (r_state == IDLE) begin
        r_par  <= 1'b0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (r_state == DATA && w_tick) begin
        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
        r_par   <= r_par ^ w_rx;
      end
      if (r_state == PARITY && w_tick) r_perr <= (w_rx ^ r_par) != 1'(PARITY_ODD);
      if (r_state == STOP && w_tick && !w_rx) r_ferr <= 1'b1;
      if (w_load) begin
        r_trans  <= r_shift;
        r_perr_o <= r_perr;
        r_ferr_o <= r_ferr | !w_rx;
        r_ovr    <= r_valid && !bus.ready;
        r_valid  <= 1'b1;
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign bus.trans      = r_trans;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_perr_o;
  assign bus.frame_err  = r_ferr_o;
  assign bus.overrun    = r_ovr;
  assign bus.busy       = r_state != IDLE;
endmodule
